// File: rtl/cpu_jogada.sv
// cpu_jogada -- CPU opponent move generator for the tic-tac-toe game core.
//
// On a request the board is captured, then the eight lines are scanned one
// per clock for a CPU win. If CPU_BLOCK_EN is defined, a second scan looks
// for a Player line to block. Failing both, the first empty cell in the
// order 4,0,2,6,8,1,3,5,7 is taken. The move comes out with a one-cycle
// valid pulse, or sem_jogada pulses if the board has no empty cell.
//
// Optional feature macro: CPU_BLOCK_EN (enables the Player-block scan).
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   pedido     in   move request, sampled only in IDLE
//   tabuleiro  in   18-bit board, cell i at [2i+1:2i]
//                   (0 Player, 1 CPU, 2 empty, 3 invalid)
//   jogada     out  chosen cell 0..8, 4'hF before any result; held
//   valida     out  one-cycle pulse, jogada valid
//   sem_jogada out  one-cycle pulse, no empty cell on the board
//   ocupado    out  high whenever the FSM is not in IDLE

module cpu_jogada (
    input  logic        clock,
    input  logic        reset,
    input  logic        pedido,
    input  logic [17:0] tabuleiro,
    output logic [3:0]  jogada,
    output logic        valida,
    output logic        sem_jogada,
    output logic        ocupado
);

    localparam logic [1:0] CELL_PLAYER = 2'd0;
    localparam logic [1:0] CELL_CPU    = 2'd1;
    localparam logic [1:0] CELL_EMPTY  = 2'd2;

    // Fallback preference, entry 0 first: 4,0,2,6,8,1,3,5,7
    localparam logic [35:0] PICK_ORDER =
        {4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4};

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SCAN_WIN   = 3'd1,
`ifdef CPU_BLOCK_EN
        SCAN_BLOCK = 3'd2,
`endif
        PICK       = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [17:0] snap;
    logic [2:0]  k;

    // Cell indices of line k: rows, columns, then the two diagonals.
    function automatic logic [11:0] line_cells(input logic [2:0] idx);
        case (idx)
            3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
            3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
            3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
            3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
            3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
            3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
            3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
            default: line_cells = {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] idx);
        cell_of = b[{idx, 1'b0} +: 2];
    endfunction

    // ---------------- line evaluation ----------------
    logic [3:0] ca, cb, cc;
    logic [1:0] va, vb, vc;
    logic [1:0] target;
    logic [1:0] n_tgt, n_emp;
    logic       scan_state;
    logic       hit;
    logic [3:0] hit_idx;

    assign {ca, cb, cc} = line_cells(k);
    assign va = cell_of(snap, ca);
    assign vb = cell_of(snap, cb);
    assign vc = cell_of(snap, cc);

`ifdef CPU_BLOCK_EN
    assign scan_state = (state == SCAN_WIN) || (state == SCAN_BLOCK);
`else
    assign scan_state = (state == SCAN_WIN);
`endif
    assign target = (state == SCAN_WIN) ? CELL_CPU : CELL_PLAYER;

    // Invalid cells (3) match neither side nor empty, so they spoil a line.
    assign n_tgt = {1'b0, va == target} + {1'b0, vb == target} + {1'b0, vc == target};
    assign n_emp = {1'b0, va == CELL_EMPTY} + {1'b0, vb == CELL_EMPTY} + {1'b0, vc == CELL_EMPTY};
    assign hit   = scan_state && (n_tgt == 2'd2) && (n_emp == 2'd1);
    assign hit_idx = (va == CELL_EMPTY) ? ca : ((vb == CELL_EMPTY) ? cb : cc);

    // ---------------- fallback pick ----------------
    logic       pick_found;
    logic [3:0] pick_idx;

    // Walk the preference list backwards so the earliest empty entry wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 4'hF;
        for (int i = 8; i >= 0; i--) begin
            if (cell_of(snap, PICK_ORDER[4*i +: 4]) == CELL_EMPTY) begin
                pick_found = 1'b1;
                pick_idx   = PICK_ORDER[4*i +: 4];
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (pedido) state_nxt = SCAN_WIN;
            SCAN_WIN: begin
                if (hit)            state_nxt = DONE;
`ifdef CPU_BLOCK_EN
                else if (k == 3'd7) state_nxt = SCAN_BLOCK;
`else
                else if (k == 3'd7) state_nxt = PICK;
`endif
            end
`ifdef CPU_BLOCK_EN
            SCAN_BLOCK: begin
                if (hit)            state_nxt = DONE;
                else if (k == 3'd7) state_nxt = PICK;
            end
`endif
            PICK:       state_nxt = DONE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / result decode ----------------
    logic       load_res;
    logic       set_sem;
    logic [3:0] res_idx;

    always_comb begin
        ocupado  = (state != IDLE);
        load_res = 1'b0;
        set_sem  = 1'b0;
        res_idx  = hit_idx;
        if (hit) begin
            load_res = 1'b1;
        end else if (state == PICK) begin
            load_res = pick_found;
            set_sem  = !pick_found;
            res_idx  = pick_idx;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap       <= 18'h2AAAA;
            k          <= 3'd0;
            jogada     <= 4'hF;
            valida     <= 1'b0;
            sem_jogada <= 1'b0;
        end else begin
            // Pulses are high only in DONE: set on the result edge, cleared after.
            valida     <= load_res;
            sem_jogada <= set_sem;
            if (load_res) jogada <= res_idx;

            if (state == IDLE && pedido) begin
                snap <= tabuleiro;
                k    <= 3'd0;
            end else if (scan_state && !hit) begin
                k <= k + 3'd1;    // 7 wraps to 0 for the next scan pass
            end
        end
    end

endmodule

// File: tb/tb_cpu_jogada.sv
module tb_cpu_jogada;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pedido = 1'b0;
    logic [17:0] tabuleiro = 18'h2AAAA;
    logic [3:0]  jogada;
    logic        valida, sem_jogada, ocupado;

    cpu_jogada dut (
        .clock(clock), .reset(reset), .pedido(pedido), .tabuleiro(tabuleiro),
        .jogada(jogada), .valida(valida), .sem_jogada(sem_jogada), .ocupado(ocupado)
    );

    always #5 clock = ~clock;

`ifdef CPU_BLOCK_EN
    localparam int PE = 17;
    localparam bit BLK = 1'b1;
`else
    localparam int PE = 9;
    localparam bit BLK = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic [8:0] cpu, input logic [8:0] ply,
                                       input logic [8:0] inv);
        logic [17:0] b;
        for (int i = 0; i < 9; i++) begin
            if (inv[i])      b[2*i +: 2] = 2'd3;
            else if (cpu[i]) b[2*i +: 2] = 2'd1;
            else if (ply[i]) b[2*i +: 2] = 2'd0;
            else             b[2*i +: 2] = 2'd2;
        end
        return b;
    endfunction

    typedef struct {
        string       name;
        logic [17:0] board;
        logic [3:0]  jog;
        logic        sem;
        int          edge_n;
    } vec_t;

    vec_t vecs[12];

    // Issue one request and check result edge, outputs and the DONE->IDLE step.
    task automatic run_req(input vec_t v);
        int  n;
        bit  got;
        @(negedge clock);
        tabuleiro = v.board;
        pedido    = 1'b1;
        @(posedge clock); #1;
        pedido    = 1'b0;
        tabuleiro = 18'h15555;          // all CPU: must be ignored after capture
        check({v.name, " ocupado after accept"}, ocupado, 1);
        n = 0; got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clock); #1;
            n++;
            if (valida || sem_jogada) got = 1'b1;
        end
        check({v.name, " result edge"}, got ? n : -1, v.edge_n);
        check({v.name, " jogada"}, jogada, v.jog);
        check({v.name, " valida"}, valida, !v.sem);
        check({v.name, " sem_jogada"}, sem_jogada, v.sem);
        @(posedge clock); #1;
        check({v.name, " pulse end/idle"}, {valida, sem_jogada, ocupado}, 0);
    endtask

    initial begin
        int  n, pulses, e1, e2;
        logic [3:0] j1, j2;

        vecs[0]  = '{"empty",       18'h2AAAA,                          4'd4, 1'b0, PE};
        vecs[1]  = '{"win_k0",      mk(9'h003, 9'h000, 9'h000),         4'd2, 1'b0, 1};
        vecs[2]  = '{"block_k2",    mk(9'h010, 9'h0C0, 9'h000),
                     BLK ? 4'd8 : 4'd0, 1'b0, BLK ? 11 : 9};
        vecs[3]  = '{"win_beats_blk", mk(9'h018, 9'h003, 9'h000),       4'd5, 1'b0, 2};
        vecs[4]  = '{"full_invalid", 18'h3FFFF,                         4'd5, 1'b1, PE};
        vecs[5]  = '{"win_k7",      mk(9'h014, 9'h000, 9'h000),         4'd6, 1'b0, 8};
        vecs[6]  = '{"win_k2_over_blk0", mk(9'h140, 9'h003, 9'h000),    4'd7, 1'b0, 3};
        vecs[7]  = '{"block_k6",    mk(9'h002, 9'h011, 9'h000),
                     BLK ? 4'd8 : 4'd2, 1'b0, BLK ? 15 : 9};
        vecs[8]  = '{"pick_last7",  mk(9'h000, 9'h000, 9'h17F),         4'd7, 1'b0, PE};
        vecs[9]  = '{"full_mixed",  mk(9'h11A, 9'h0E5, 9'h000),         4'd7, 1'b1, PE};
        vecs[10] = '{"inv_spoils",  mk(9'h003, 9'h000, 9'h004),         4'd4, 1'b0, PE};
        vecs[11] = '{"three_cpu",   mk(9'h007, 9'h000, 9'h000),         4'd4, 1'b0, PE};

        // reset state
        #12;
        check("reset jogada", jogada, 4'hF);
        check("reset pulses/ocupado", {valida, sem_jogada, ocupado}, 0);
        @(negedge clock); reset = 1'b0;

        foreach (vecs[i]) run_req(vecs[i]);

        // reset mid-scan: aborts immediately, no pulse afterwards
        @(negedge clock);
        tabuleiro = 18'h2AAAA; pedido = 1'b1;
        @(posedge clock); #1; pedido = 1'b0;
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("midreset ocupado", ocupado, 0);
        check("midreset jogada", jogada, 4'hF);
        check("midreset valida", valida, 0);
        @(negedge clock); reset = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (valida || sem_jogada) pulses++;
        end
        check("no pulse after reset", pulses, 0);
        run_req(vecs[1]);

        // pedido raised mid-scan is ignored; held, it re-triggers after DONE
        @(negedge clock);
        tabuleiro = 18'h2AAAA; pedido = 1'b1;
        @(posedge clock); #1;
        pedido = 1'b0;
        tabuleiro = mk(9'h003, 9'h000, 9'h000);
        repeat (2) @(posedge clock);
        #1 pedido = 1'b1;
        n = 2; pulses = 0; e1 = -1; e2 = -1; j1 = 4'hF; j2 = 4'hF;
        while (n < 60 && pulses < 2) begin
            @(posedge clock); #1;
            n++;
            if (valida) begin
                pulses++;
                if (pulses == 1) begin e1 = n; j1 = jogada; end
                else begin e2 = n; j2 = jogada; pedido = 1'b0; end
            end
        end
        pedido = 1'b0;
        check("held first edge", e1, PE);
        check("held first jogada", j1, 4'd4);
        check("retrigger edge", e2, PE + 3);
        check("retrigger jogada", j2, 4'd2);
        repeat (2) @(posedge clock);
        #1 check("final idle", ocupado, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
